// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Load-use bubbles, branch flushes, memory-wait freeze and halt drain.
module pipeline_ctrl #(
  parameter int CNT_W     = 16,
  parameter int WAIT_MAX  = 255,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_pc_src,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;
  logic          resume_drain;
  logic          load_use;
  logic          mem_busy;
  logic          stall_cyc;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) ||
                     (id_uses_rt && (ex_rt == id_rt)));
  assign mem_busy = dmem_req && !dmem_ready;
  assign halted   = (state == S_HALT);

  assign stall_cyc = !pc_write &&
                     ((state == S_RUN) || (state == S_WAIT));

  // Pipeline enables decoded from current state and hazards
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      unique case (state)
        S_RUN: begin
          if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
          end else if (mem_pc_src) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (id_halt) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        S_WAIT: begin
          if (!dmem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
          end
        end
        S_DRAIN: begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
        end
        S_HALT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, wait/drain timers and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      drain_cnt    <= '0;
      resume_drain <= 1'b0;
      err_timeout  <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      if (stall_cyc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        S_RUN: begin
          if (mem_busy) begin
            wait_cnt <= WW'(1);
            state    <= S_WAIT;
          end else if (mem_pc_src) begin
            if (flush_cnt != '1)
              flush_cnt <= flush_cnt + 1'b1;
          end else if (id_halt) begin
            drain_cnt <= DW'(1);
            state     <= S_DRAIN;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            state        <= resume_drain ? S_DRAIN : S_RUN;
            resume_drain <= 1'b0;
          end else if (wait_cnt == WW'(WAIT_MAX)) begin
            err_timeout  <= 1'b1;
            resume_drain <= 1'b0;
            state        <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (mem_busy) begin
            resume_drain <= 1'b1;
            wait_cnt     <= WW'(1);
            state        <= S_WAIT;
          end else if (drain_cnt == DW'(DRAIN_CYC)) begin
            state <= S_HALT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_HALT: ;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl.
// Directed scenarios then random traffic against a cycle reference model.
module tb_pipeline_ctrl;

  localparam int CW   = 4;
  localparam int WMAX = 4;
  localparam int DCYC = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_halt, ex_mem_read;
  logic          mem_pc_src, dmem_req, dmem_ready;
  logic          pc_write, ifid_write, ifid_flush;
  logic          idex_flush, exmem_flush, pipe_hold;
  logic          halted, err_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: freeze/drain/halt progress in plain integers
  bit m_wait, m_halt, m_err;
  int m_wlen, m_drain, m_stall, m_flush;

  pipeline_ctrl #(
    .CNT_W(CW), .WAIT_MAX(WMAX), .DRAIN_CYC(DCYC)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_pc_src(mem_pc_src),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .halted(halted), .err_timeout(err_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit r, input int rs, input int rt,
                       input bit ur, input bit h, input bit mr,
                       input int xr, input bit br,
                       input bit rq, input bit rd);
    rst = r;
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_uses_rt = ur;
    id_halt = h;
    ex_mem_read = mr;
    ex_rt = 5'(xr);
    mem_pc_src = br;
    dmem_req = rq;
    dmem_ready = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int sat(input int v);
    return (v + 1 > SAT) ? SAT : v + 1;
  endfunction

  // one clock: check enables mid-cycle, step model, check registers
  task automatic cyc();
    logic [5:0] exp_c, got_c;
    bit lu, busy, stall;
    lu = ex_mem_read && ex_rt != 0 &&
         (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    busy = dmem_req && !dmem_ready;
    stall = 0;
    exp_c = 6'b110000;
    #4;
    if (rst) begin
      exp_c = 6'b001110;
      m_wait = 0; m_halt = 0; m_err = 0;
      m_wlen = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    end else if (m_halt) begin
      exp_c = 6'b000001;
    end else if (m_wait) begin
      if (dmem_ready) begin
        m_wait = 0;
      end else begin
        exp_c = 6'b000001;
        stall = 1;
        if (m_wlen == WMAX) begin
          m_err = 1; m_halt = 1; m_wait = 0;
        end else begin
          m_wlen++;
        end
      end
    end else if (m_drain > 0) begin
      exp_c = 6'b011000;
      if (busy) begin
        m_wait = 1; m_wlen = 1;
      end else if (m_drain == DCYC) begin
        m_halt = 1;
      end else begin
        m_drain++;
      end
    end else if (busy) begin
      exp_c = 6'b000001; stall = 1;
      m_wait = 1; m_wlen = 1;
    end else if (mem_pc_src) begin
      exp_c = 6'b111110;
      m_flush = sat(m_flush);
    end else if (id_halt) begin
      exp_c = 6'b011000; stall = 1;
      m_drain = 1;
    end else if (lu) begin
      exp_c = 6'b000100; stall = 1;
    end
    if (stall) m_stall = sat(m_stall);
    got_c = {pc_write, ifid_write, ifid_flush,
             idex_flush, exmem_flush, pipe_hold};
    checks++;
    assert (got_c === exp_c) else begin
      errors++;
      $error("FAIL ctrl t=%0t got %b exp %b", $time, got_c, exp_c);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (halted === m_halt) else begin
      errors++;
      $error("FAIL halted got %b exp %b", halted, m_halt);
    end
    checks++;
    assert (err_timeout === m_err) else begin
      errors++;
      $error("FAIL err_timeout got %b exp %b", err_timeout, m_err);
    end
    checks++;
    assert (stall_cnt === CW'(m_stall)) else begin
      errors++;
      $error("FAIL stall_cnt got %0d exp %0d", stall_cnt, m_stall);
    end
    checks++;
    assert (flush_cnt === CW'(m_flush)) else begin
      errors++;
      $error("FAIL flush_cnt got %0d exp %0d", flush_cnt, m_flush);
    end
  endtask

  task automatic reset_cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  initial begin
    reset_cyc();
    // load-use on rs
    drive(0, 2, 5, 0, 0, 1, 2, 0, 0, 0); cyc();
    idle(); cyc();
    // load-use on rt only when used
    drive(0, 7, 3, 1, 0, 1, 3, 0, 0, 0); cyc();
    drive(0, 7, 3, 0, 0, 1, 3, 0, 0, 0); cyc();
    // $zero never hazards
    drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); cyc();
    // taken branch overrides load-use
    drive(0, 2, 0, 0, 0, 1, 2, 1, 0, 0); cyc();
    // memory wait of three hold cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc(); cyc(); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); cyc();
    idle(); cyc();
    // timeout into halt, inputs ignored, then reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (6) cyc();
    drive(0, 2, 0, 0, 1, 1, 2, 1, 1, 1); cyc();
    reset_cyc();
    // plain drain
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cyc();
    idle();
    repeat (6) cyc();
    reset_cyc();
    // drain suspended by a memory wait
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cyc();
    idle(); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc();
    idle();
    repeat (5) cyc();
    reset_cyc();
    // counter saturation
    drive(0, 4, 0, 0, 0, 1, 4, 0, 0, 0);
    repeat (SAT + 3) cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (SAT + 3) cyc();
    reset_cyc();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0),
            $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
